// File: rtl/vga_pkg.sv
// Shared VGA definitions: 800x600@72 raster timing, colour widths and pixel type.
// Also used by the maze ROM and the game logic.
package vga_pkg;

    // 800x600 @ 72 Hz on a 50 MHz pixel clock
    localparam int H_VISIBLE = 800;
    localparam int H_FRONT   = 56;
    localparam int H_SYNC    = 120;
    localparam int H_BACK    = 64;
    localparam int V_VISIBLE = 600;
    localparam int V_FRONT   = 37;
    localparam int V_SYNC    = 6;
    localparam int V_BACK    = 23;
    localparam int SYNC_POL  = 1;     // 1 = active-high sync pulses

    // Scan coordinate width
    localparam int COORD_W   = 11;

    // Colour channel widths (rgb332)
    localparam int R_W       = 3;
    localparam int G_W       = 3;
    localparam int B_W       = 2;

    typedef struct packed {
        logic [R_W-1:0] r;
        logic [G_W-1:0] g;
        logic [B_W-1:0] b;
    } rgb332_t;

    // Total period of a raster axis from its four segments
    function automatic int axis_total(input int vis, input int fp, input int sw, input int bp);
        return vis + fp + sw + bp;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// DEPTH x WIDTH shift register used to align raster flags with the colour pipeline.
// DEPTH = 0 degenerates to a plain wire.
module vga_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign o_data = i_data;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [DEPTH];

            for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
                if (gi == 0) begin : g_first
                    // First stage captures the live input
                    always_ff @(posedge i_clk or posedge i_rst) begin
                        if (i_rst) r_stage[gi] <= '0;
                        else       r_stage[gi] <= i_data;
                    end
                end else begin : g_next
                    // Later stages shift the previous stage along
                    always_ff @(posedge i_clk or posedge i_rst) begin
                        if (i_rst) r_stage[gi] <= '0;
                        else       r_stage[gi] <= r_stage[gi-1];
                    end
                end
            end

            assign o_data = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster generator. Emits scan coordinates to the colour stage,
// then blanks its returned colour and drives sync, both delayed to match that
// stage's latency so colour and sync reach the connector together.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE  = vga_pkg::H_VISIBLE,
    parameter int H_FRONT    = vga_pkg::H_FRONT,
    parameter int H_SYNC     = vga_pkg::H_SYNC,
    parameter int H_BACK     = vga_pkg::H_BACK,
    parameter int V_VISIBLE  = vga_pkg::V_VISIBLE,
    parameter int V_FRONT    = vga_pkg::V_FRONT,
    parameter int V_SYNC     = vga_pkg::V_SYNC,
    parameter int V_BACK     = vga_pkg::V_BACK,
    parameter int SYNC_POL   = vga_pkg::SYNC_POL,
    parameter int PIPE_DELAY = 1
) (
    input  logic               uclk,
    input  logic               reset,
    output logic [COORD_W-1:0] PixelX,
    output logic [COORD_W-1:0] PixelY,
    output logic               VideoOn,
    output logic               FrameStart,
    input  logic [R_W-1:0]     RIn,
    input  logic [G_W-1:0]     GIn,
    input  logic [B_W-1:0]     BIn,
    output logic [R_W-1:0]     ROut,
    output logic [G_W-1:0]     GOut,
    output logic [B_W-1:0]     BOut,
    output logic               HSync,
    output logic               VSync
);

    localparam int H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    // Refuse to build a mode whose counters would not fit, or an unsupported delay
    generate
        if (H_TOTAL > (2 ** COORD_W) || V_TOTAL > (2 ** COORD_W)) begin : g_bad_total
            $error("vga_timing_gen: raster totals exceed counter width");
        end
        if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_delay
            $error("vga_timing_gen: PIPE_DELAY must be 0..7");
        end
    endgenerate

    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_VISIBLE);
    localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_VISIBLE);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_VISIBLE + H_FRONT);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_VISIBLE + V_FRONT);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    // Pin level while sync is not asserted; also the XOR mask for polarity
    localparam logic SYNC_INACT = (SYNC_POL != 0) ? 1'b0 : 1'b1;

    logic [COORD_W-1:0] r_pixel_x;
    logic [COORD_W-1:0] r_pixel_y;
    logic               w_h_wrap;
    logic               w_video_on;
    logic               w_hs_raw;
    logic               w_vs_raw;
    logic [2:0]         w_flags_d;
    rgb332_t            w_rgb_in;
    rgb332_t            r_rgb_out;
    logic               r_hsync;
    logic               r_vsync;

    assign w_h_wrap = (r_pixel_x == H_LAST);

    // Raster counters: X every clock, Y once per line, both wrapping at their totals
    always_ff @(posedge uclk or posedge reset) begin
        if (reset) begin
            r_pixel_x <= '0;
            r_pixel_y <= '0;
        end else begin
            r_pixel_x <= w_h_wrap ? '0 : r_pixel_x + 1'b1;
            if (w_h_wrap) begin
                r_pixel_y <= (r_pixel_y == V_LAST) ? '0 : r_pixel_y + 1'b1;
            end
        end
    end

    // Undelayed raster decodes for the coordinate currently presented
    assign w_video_on = (r_pixel_x < H_VIS) && (r_pixel_y < V_VIS);
    assign w_hs_raw   = (r_pixel_x >= HS_START) && (r_pixel_x <= HS_END);
    assign w_vs_raw   = (r_pixel_y >= VS_START) && (r_pixel_y <= VS_END);

    // Align the flags with the colour that the downstream stage will return
    vga_delay_line #(
        .DEPTH (PIPE_DELAY),
        .WIDTH (3)
    ) u_flag_delay (
        .i_clk  (uclk),
        .i_rst  (reset),
        .i_data ({w_video_on, w_hs_raw, w_vs_raw}),
        .o_data (w_flags_d)
    );

    assign w_rgb_in = '{r: RIn, g: GIn, b: BIn};

    // Output register: blank colour outside the active area, apply sync polarity
    always_ff @(posedge uclk or posedge reset) begin
        if (reset) begin
            r_rgb_out <= '0;
            r_hsync   <= SYNC_INACT;
            r_vsync   <= SYNC_INACT;
        end else begin
            r_rgb_out <= w_flags_d[2] ? w_rgb_in : '0;
            r_hsync   <= w_flags_d[1] ^ SYNC_INACT;
            r_vsync   <= w_flags_d[0] ^ SYNC_INACT;
        end
    end

    assign PixelX     = r_pixel_x;
    assign PixelY     = r_pixel_y;
    assign VideoOn    = w_video_on;
    // Held low while reset is asserted even though the counters already read (0,0)
    assign FrameStart = (r_pixel_x == '0) && (r_pixel_y == '0) && !reset;
    assign ROut       = r_rgb_out.r;
    assign GOut       = r_rgb_out.g;
    assign BOut       = r_rgb_out.b;
    assign HSync      = r_hsync;
    assign VSync      = r_vsync;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen. Three instances run side by side:
//   0: 800x600@72 default, PIPE_DELAY=1, active-high sync
//   1: tiny 16x12 raster, PIPE_DELAY=3, active-low sync (full frames are cheap)
//   2: 640x480@60 timing, PIPE_DELAY=0
// A bench-side colour stage returns f(x,y) delayed by PIPE_DELAY (or all-ones).
module tb_vga_timing_gen;

    typedef struct {
        int hv, hf, hs, hb, vv, vf, vs, vb, pol, dly;
    } cfg_t;

    logic        clk;
    logic [2:0]  rst_v;
    logic        const_rgb;

    logic [10:0] px [3];
    logic [10:0] py [3];
    logic        von [3];
    logic        fs  [3];
    logic        hsy [3];
    logic        vsy [3];
    logic [7:0]  rgb_out [3];
    logic [7:0]  rgb_in  [3];

    logic [10:0] hx [3][3];
    logic [10:0] hy [3][3];

    int n_cmp;
    int n_err;

    // per-run observations
    int fs_cnt, fs_first, fs_second, max_x, max_y, hs_act, vs_act;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic cfg_t get_cfg(input int sel);
        cfg_t c;
        case (sel)
            0:       c = '{800, 56, 120, 64, 600, 37, 6, 23, 1, 1};
            1:       c = '{8, 2, 3, 3, 6, 2, 2, 2, 0, 3};
            default: c = '{640, 16, 96, 48, 480, 10, 2, 33, 1, 0};
        endcase
        return c;
    endfunction

    function automatic logic [7:0] fcol(input int x, input int y);
        logic [7:0] a;
        logic [7:0] b;
        a = x[7:0];
        b = {y[4:0], 3'b000};
        return a ^ b;
    endfunction

    // Bench colour stage: coordinate history, one register per clock of delay
    always @(posedge clk) begin
        for (int s = 0; s < 3; s++) begin
            hx[s][0] <= px[s];
            hy[s][0] <= py[s];
            for (int i = 1; i < 3; i++) begin
                hx[s][i] <= hx[s][i-1];
                hy[s][i] <= hy[s][i-1];
            end
        end
    end

    assign rgb_in[0] = const_rgb ? 8'hFF : fcol(int'(hx[0][0]), int'(hy[0][0]));
    assign rgb_in[1] = const_rgb ? 8'hFF : fcol(int'(hx[1][2]), int'(hy[1][2]));
    assign rgb_in[2] = const_rgb ? 8'hFF : fcol(int'(px[2]), int'(py[2]));

    vga_timing_gen #(
        .PIPE_DELAY (1)
    ) u_dut_a (
        .uclk (clk), .reset (rst_v[0]),
        .PixelX (px[0]), .PixelY (py[0]), .VideoOn (von[0]), .FrameStart (fs[0]),
        .RIn (rgb_in[0][7:5]), .GIn (rgb_in[0][4:2]), .BIn (rgb_in[0][1:0]),
        .ROut (rgb_out[0][7:5]), .GOut (rgb_out[0][4:2]), .BOut (rgb_out[0][1:0]),
        .HSync (hsy[0]), .VSync (vsy[0])
    );

    vga_timing_gen #(
        .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
        .V_VISIBLE (6), .V_FRONT (2), .V_SYNC (2), .V_BACK (2),
        .SYNC_POL (0), .PIPE_DELAY (3)
    ) u_dut_b (
        .uclk (clk), .reset (rst_v[1]),
        .PixelX (px[1]), .PixelY (py[1]), .VideoOn (von[1]), .FrameStart (fs[1]),
        .RIn (rgb_in[1][7:5]), .GIn (rgb_in[1][4:2]), .BIn (rgb_in[1][1:0]),
        .ROut (rgb_out[1][7:5]), .GOut (rgb_out[1][4:2]), .BOut (rgb_out[1][1:0]),
        .HSync (hsy[1]), .VSync (vsy[1])
    );

    vga_timing_gen #(
        .H_VISIBLE (640), .H_FRONT (16), .H_SYNC (96), .H_BACK (48),
        .V_VISIBLE (480), .V_FRONT (10), .V_SYNC (2), .V_BACK (33),
        .SYNC_POL (1), .PIPE_DELAY (0)
    ) u_dut_c (
        .uclk (clk), .reset (rst_v[2]),
        .PixelX (px[2]), .PixelY (py[2]), .VideoOn (von[2]), .FrameStart (fs[2]),
        .RIn (rgb_in[2][7:5]), .GIn (rgb_in[2][4:2]), .BIn (rgb_in[2][1:0]),
        .ROut (rgb_out[2][7:5]), .GOut (rgb_out[2][4:2]), .BOut (rgb_out[2][1:0]),
        .HSync (hsy[2]), .VSync (vsy[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Outputs held while reset is asserted
    task automatic check_reset(input int sel, input string tag);
        cfg_t c;
        logic inact;
        c = get_cfg(sel);
        inact = (c.pol == 0);
        chk($sformatf("%s[%0d] PixelX", tag, sel), 32'(px[sel]), 32'd0);
        chk($sformatf("%s[%0d] PixelY", tag, sel), 32'(py[sel]), 32'd0);
        chk($sformatf("%s[%0d] VideoOn", tag, sel), 32'(von[sel]), 32'd1);
        chk($sformatf("%s[%0d] FrameStart", tag, sel), 32'(fs[sel]), 32'd0);
        chk($sformatf("%s[%0d] RGB", tag, sel), 32'(rgb_out[sel]), 32'd0);
        chk($sformatf("%s[%0d] HSync", tag, sel), 32'(hsy[sel]), 32'(inact));
        chk($sformatf("%s[%0d] VSync", tag, sel), 32'(vsy[sel]), 32'(inact));
    endtask

    // Compare every output against the raster expected n clocks after release
    task automatic check_state(input int sel, input int n);
        cfg_t c;
        int ht, vt, x, y, m, mx, my;
        logic inact;
        logic [7:0] exp_rgb;
        logic exp_hs, exp_vs;
        c = get_cfg(sel);
        ht = c.hv + c.hf + c.hs + c.hb;
        vt = c.vv + c.vf + c.vs + c.vb;
        x = n % ht;
        y = (n / ht) % vt;
        inact = (c.pol == 0);
        m = n - c.dly - 1;
        exp_rgb = 8'h00;
        exp_hs = inact;
        exp_vs = inact;
        if (m >= 0) begin
            mx = m % ht;
            my = (m / ht) % vt;
            if (mx < c.hv && my < c.vv) exp_rgb = const_rgb ? 8'hFF : fcol(mx, my);
            exp_hs = ((mx >= c.hv + c.hf) && (mx < c.hv + c.hf + c.hs)) ^ inact;
            exp_vs = ((my >= c.vv + c.vf) && (my < c.vv + c.vf + c.vs)) ^ inact;
        end
        chk($sformatf("[%0d] n=%0d PixelX", sel, n), 32'(px[sel]), 32'(x));
        chk($sformatf("[%0d] n=%0d PixelY", sel, n), 32'(py[sel]), 32'(y));
        chk($sformatf("[%0d] n=%0d VideoOn", sel, n), 32'(von[sel]), 32'(x < c.hv && y < c.vv));
        chk($sformatf("[%0d] n=%0d FrameStart", sel, n), 32'(fs[sel]), 32'(x == 0 && y == 0));
        chk($sformatf("[%0d] n=%0d RGB", sel, n), 32'(rgb_out[sel]), 32'(exp_rgb));
        chk($sformatf("[%0d] n=%0d HSync", sel, n), 32'(hsy[sel]), 32'(exp_hs));
        chk($sformatf("[%0d] n=%0d VSync", sel, n), 32'(vsy[sel]), 32'(exp_vs));

        // hand-computed alignment points: last visible pixel then first blanked one
        if (sel == 0 && !const_rgb && n == 1841) chk("A rgb(799,1)", 32'(rgb_out[0]), 32'h17);
        if (sel == 0 && !const_rgb && n == 1842) chk("A rgb(800,1)", 32'(rgb_out[0]), 32'h00);
        if (sel == 1 && n == 91) chk("B rgb(7,5)", 32'(rgb_out[1]), 32'h2F);
        if (sel == 1 && n == 92) chk("B rgb(8,5)", 32'(rgb_out[1]), 32'h00);

        if (fs[sel]) begin
            if (fs_cnt == 0) fs_first = n;
            if (fs_cnt == 1) fs_second = n;
            fs_cnt++;
        end
        if (int'(px[sel]) > max_x) max_x = int'(px[sel]);
        if (int'(py[sel]) > max_y) max_y = int'(py[sel]);
        if (hsy[sel] ^ inact) hs_act++;
        if (vsy[sel] ^ inact) vs_act++;
    endtask

    // Called at a falling edge with the instance held in reset
    task automatic release_run(input int sel, input int ncyc);
        fs_cnt = 0; fs_first = -1; fs_second = -1;
        max_x = 0; max_y = 0; hs_act = 0; vs_act = 0;
        rst_v[sel] = 1'b0;
        for (int n = 0; n <= ncyc; n++) begin
            if (n > 0) @(negedge clk);
            #1;
            check_state(sel, n);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_v = 3'b111;
        const_rgb = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        for (int s = 0; s < 3; s++) check_reset(s, "reset");
        $display("reset: all three instances checked at reset values");

        // Default mode, all-ones colour: blanking and HSync over two lines
        @(negedge clk);
        release_run(0, 2100);
        chk("A hsync active clocks", 32'(hs_act), 32'd240);
        chk("A first FrameStart n", 32'(fs_first), 32'd0);
        $display("blanking 800x600: 2101 clocks, hsync active %0d", hs_act);

        // Default mode, coordinate-dependent colour: alignment
        rst_v[0] = 1'b1;
        const_rgb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        release_run(0, 2100);
        $display("alignment 800x600 PIPE_DELAY=1: 2101 clocks");

        // Asynchronous reset mid-line at (500,1)
        rst_v[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        release_run(0, 1540);
        chk("A pre-reset PixelX", 32'(px[0]), 32'd500);
        #1 rst_v[0] = 1'b1;
        #1;
        check_reset(0, "async");
        repeat (3) @(posedge clk);
        @(negedge clk);
        release_run(0, 1100);
        $display("mid-line reset at (500,1): restart from (0,0) checked");

        // Tiny raster: whole frames, frame length, extremes, active-low VSync, delay 3
        const_rgb = 1'b0;
        @(negedge clk);
        release_run(1, 394);
        chk("B FrameStart count", 32'(fs_cnt), 32'd3);
        chk("B frame length", 32'(fs_second - fs_first), 32'd192);
        chk("B max PixelX", 32'(max_x), 32'd15);
        chk("B max PixelY", 32'(max_y), 32'd11);
        chk("B vsync active clocks", 32'(vs_act), 32'd64);
        $display("tiny 16x12 raster: frame %0d clocks, vsync active %0d", fs_second - fs_first, vs_act);

        // 640x480 timing with no delay stage: HSync width
        const_rgb = 1'b1;
        @(negedge clk);
        release_run(2, 1700);
        chk("C hsync active clocks", 32'(hs_act), 32'd192);
        $display("640x480 PIPE_DELAY=0: hsync active %0d over two lines", hs_act);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
